// File: rtl/mips_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// FSM encoding, register bit positions and small helpers.
package mips_uart_tx_pkg;

  localparam logic [1:0] UART_DATA    = 2'd0;
  localparam logic [1:0] UART_CTRL    = 2'd1;
  localparam logic [1:0] UART_STATUS  = 2'd2;
  localparam logic [1:0] UART_DIVISOR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

  // STATUS only has a 4-bit count field, so larger occupancies clamp to 15.
  function automatic logic [3:0] sat_count(input logic [31:0] cnt);
    if (cnt > 32'd15) begin
      return 4'hF;
    end else begin
      return cnt[3:0];
    end
  endfunction

  // A programmed divisor of 0 is treated as 1 cycle per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    if (div == 16'd0) begin
      return 16'd1;
    end else begin
      return div;
    end
  endfunction

endpackage

// File: rtl/mips_uart_fifo.sv
// Synchronous FIFO with one extra pointer bit to tell full from empty.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module mips_uart_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW:0]   wptr_r;
  logic [AW:0]   rptr_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign empty     = (wptr_r == rptr_r);
  assign count     = wptr_r - rptr_r;
  assign full      = (count == (AW+1)'(DEPTH));
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign rdata     = mem_r[rptr_r[AW-1:0]];

  // Pointer update; both pointers wrap naturally through the extra MSB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (push_ok_s) wptr_r <= wptr_r + (AW+1)'(1);
      if (pop_ok_s)  rptr_r <= rptr_r + (AW+1)'(1);
    end
  end

  // Storage array, write side only.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wptr_r[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mips_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register file, TX FIFO, baud counter,
// framing FSM and a level IRQ raised once the FIFO has drained.
module mips_uart_tx
  import mips_uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e     state_r;
  tx_state_e     state_nx_s;
  logic [15:0]   div_r;
  logic [15:0]   cnt_r;
  logic [15:0]   cnt_nx_s;
  logic [15:0]   reload_s;
  logic [2:0]    idx_r;
  logic [2:0]    idx_nx_s;
  logic [7:0]    shreg_r;
  logic [7:0]    shreg_nx_s;
  logic [7:0]    fifo_rdata_s;
  logic          tx_r;
  logic          tx_nx_s;
  logic          irq_r;
  logic          en_r;
  logic          irq_en_r;
  logic          ovf_r;
  logic [1:0]    reg_sel_s;
  logic          wr_data_s;
  logic          wr_ctrl_s;
  logic          wr_status_s;
  logic          wr_div_s;
  logic          pop_s;
  logic          busy_s;
  logic          full_s;
  logic          empty_s;
  logic [CW-1:0] count_s;
  logic          unused_s;

  assign reg_sel_s   = Addr[1:0];
  assign wr_data_s   = WE && (reg_sel_s == UART_DATA);
  assign wr_ctrl_s   = WE && (reg_sel_s == UART_CTRL);
  assign wr_status_s = WE && (reg_sel_s == UART_STATUS);
  assign wr_div_s    = WE && (reg_sel_s == UART_DIVISOR);
  assign busy_s      = (state_r != ST_IDLE);
  assign pop_s       = (state_r == ST_IDLE) && en_r && !empty_s;
  assign reload_s    = eff_div(div_r) - 16'd1;
  assign tx          = tx_r;
  assign IRQ         = irq_r;
  assign unused_s    = ^{Addr[29:2], Din[31:16]};

  mips_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data_s),
    .wdata (Din[7:0]),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Software-visible registers; overflow is sticky until STATUS bit 3 is written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_r     <= 1'b0;
      irq_en_r <= 1'b0;
      div_r    <= DIV_RESET;
      ovf_r    <= 1'b0;
    end else begin
      if (wr_ctrl_s) begin
        en_r     <= Din[CTRL_EN];
        irq_en_r <= Din[CTRL_IRQ_EN];
      end
      if (wr_div_s) div_r <= Din[15:0];
      if (wr_data_s && full_s && !pop_s) begin
        ovf_r <= 1'b1;
      end else if (wr_status_s && Din[STAT_OVF]) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // Framing state, baud counter, shifter and the registered line/IRQ outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 16'd0;
      idx_r   <= 3'd0;
      shreg_r <= 8'd0;
      tx_r    <= 1'b1;
      irq_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      idx_r   <= idx_nx_s;
      shreg_r <= shreg_nx_s;
      tx_r    <= tx_nx_s;
      irq_r   <= irq_en_r && en_r && empty_s && !busy_s;
    end
  end

  // Next-state logic; every bit period reloads from the live DIVISOR value.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    idx_nx_s   = idx_r;
    shreg_nx_s = shreg_r;
    tx_nx_s    = 1'b1;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          state_nx_s = ST_START;
          shreg_nx_s = fifo_rdata_s;
          cnt_nx_s   = reload_s;
        end else begin
          cnt_nx_s   = cnt_r;
        end
      end
      ST_START: begin
        if (cnt_r == 16'd0) begin
          state_nx_s = ST_DATA;
          idx_nx_s   = 3'd0;
          cnt_nx_s   = reload_s;
        end else begin
          cnt_nx_s   = cnt_r - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_r == 16'd0) begin
          cnt_nx_s = reload_s;
          if (idx_r == 3'd7) begin
            state_nx_s = ST_STOP;
          end else begin
            idx_nx_s   = idx_r + 3'd1;
          end
        end else begin
          cnt_nx_s = cnt_r - 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_r == 16'd0) begin
          state_nx_s = ST_IDLE;
        end else begin
          cnt_nx_s   = cnt_r - 16'd1;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
    case (state_nx_s)
      ST_START: tx_nx_s = 1'b0;
      ST_DATA:  tx_nx_s = shreg_nx_s[idx_nx_s];
      default:  tx_nx_s = 1'b1;
    endcase
  end

  // Read mux; a same-cycle write is visible only after the clock edge.
  always_comb begin
    Dout = 32'd0;
    case (reg_sel_s)
      UART_DATA:    Dout = 32'd0;
      UART_CTRL:    Dout = {30'd0, irq_en_r, en_r};
      UART_STATUS:  Dout = {24'd0, sat_count(32'(count_s)), ovf_r, empty_s, full_s, busy_s};
      UART_DIVISOR: Dout = {16'd0, div_r};
      default:      Dout = 32'd0;
    endcase
  end

endmodule
